servo_ramp_ctrl: RTL and testbench
==================================

// Module: servo_ramp_ctrl
// PURPOSE
// Upstream command stage for the SimpleServo pulse generator: accepts target positions over a valid/ready
// handshake and slews position_o toward the target by a fixed step once per update period.
// Drives SimpleServo's position_i/en_i directly, so servo motion is rate-limited regardless of command timing.
// PARAMETERS
// CLK_PER_NS  40          clock period in ns; ms tick period = (1_000_000/CLK_PER_NS)+1 cycles
// N           8           position width; must match SimpleServo N
// STEP_MS     20          ms ticks per position update (one servo frame); >=1
// STEP        4           max position change per update; 1 <= STEP < 2**N
// INIT_POS    2**(N-1)    position_o and target after reset (servo centre)
// PORTS
// clk_i         in   1   system clock, single domain
// rst_i         in   1   synchronous reset, active-high
// enable_i      in   1   global enable; low forces OFF state
// cmd_valid_i   in   1   target command valid
// cmd_target_i  in   N   requested target position
// cmd_ready_o   out  1   command accepted when valid&&ready
// position_o    out  N   current position to SimpleServo position_i
// en_o          out  1   servo enable to SimpleServo en_i
// busy_o        out  1   high while position_o != target
// done_o        out  1   one-cycle pulse when position_o reaches target
// BEHAVIOUR
// - Reset (sync, rst_i high at clk edge): state=OFF, position_o=target=INIT_POS, en_o=0, cmd_ready_o=0,
//   busy_o=0, done_o=0, tick and update counters=0. Reset wins over every other input.
// - ms tick: counter 0..MS/CLK_PER_NS, wraps with 1-cycle tick at terminal count; update counter counts
//   STEP_MS ticks -> 1-cycle upd pulse. Both counters held at 0 in OFF.
// - States: OFF, IDLE (settled), RAMP. en_o = (state != OFF). busy_o = (state == RAMP).
// - OFF: enable_i high -> IDLE next cycle; position_o and target keep their values.
// - Any state, enable_i low -> OFF next cycle; position_o frozen; no done_o; target kept.
// - cmd_ready_o = enable_i && state != OFF (combinational from state and enable_i).
// - IDLE, accept: target<=cmd_target_i; equal to position_o -> stay IDLE, done_o pulse next cycle;
//   else -> RAMP, tick/update counters cleared so first step is STEP_MS*(MS/CLK_PER_NS+1) cycles later.
// - RAMP, upd: d = target - position_o on N+1 signed bits; |d| <= STEP -> position_o<=target,
//   -> IDLE, done_o=1 same edge; else position_o <= position_o +/- STEP. Never over/undershoots, no wrap.
// - RAMP, accept (retarget): target replaced, counters not cleared; if accept and upd coincide the step is
//   computed toward cmd_target_i. New target equal to position_o -> IDLE with done_o pulse.
// - position_o changes only on upd edges (or reset); SimpleServo samples it freely.
// - done_o never asserts in the same cycle as en_o low.
// STRUCTURE
// - Shared package servo_pkg: MS=1_000_000 constant, state encoding localparams (OFF/IDLE/RAMP),
//   MS_TICKS(CLK_PER_NS) helper; reused by SimpleServo refactor.
// - One sub-module: servo_ms_tick (params CLK_PER_NS, STEP_MS; ports clk_i, rst_i, clr_i -> tick_o, upd_o).
// - Remainder (FSM, target reg, clamped step datapath) in this module.
// TESTING (bench uses CLK_PER_NS=100_000 -> 11-cycle tick, STEP_MS=2 -> 22-cycle update, N=8, STEP=4)
// 1. Reset then enable_i=1 -> en_o=1 after 1 cycle, position_o=128, busy_o=0, cmd_ready_o=1.
// 2. Accept target 140 -> busy_o=1; position_o 132,136,140 at 22,44,66 cycles; done_o pulse at 66; IDLE.
// 3. Accept target 126 from 128 -> position_o=126 at first update (clamp, |d|=2<=STEP), done_o pulse.
// 4. Retarget 100 while ramping 128->140 at position 132 -> next updates 128,124..., settles at 100 with
//    single done_o; accept coinciding with upd steps toward new target.
// 5. enable_i low mid-ramp at position 136 -> en_o=0, cmd_ready_o=0 next cycle, position_o stays 136,
//    no done_o; enable_i high -> IDLE, target retained; rst_i mid-ramp -> position_o=128, OFF.
// 6. Accept target equal to position_o (128) -> no state change to RAMP, done_o pulse 1 cycle later.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo constants, state encoding and the ms tick helper.
package servo_pkg;

  localparam int unsigned MS = 1_000_000;

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] RAMP = 2'd2;

  typedef enum logic [1:0] {
    ST_OFF  = OFF,
    ST_IDLE = IDLE,
    ST_RAMP = RAMP
  } state_t;

  // Terminal count of the ms counter; the tick period is this value plus one.
  function automatic int unsigned MS_TICKS(input int unsigned clk_per_ns);
    return MS / clk_per_ns;
  endfunction

endpackage

// File: rtl/servo_ms_tick.sv
// ms tick and per-update pulse generator; tick_o/upd_o are 1-cycle pulses, no backpressure.
// clr_i restarts both counters so the next update lands a full STEP_MS ticks later.
module servo_ms_tick
  import servo_pkg::*;
#(
  parameter int unsigned CLK_PER_NS = 40,
  parameter int unsigned STEP_MS    = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o,
  output logic upd_o
);

  localparam int unsigned TC = MS_TICKS(CLK_PER_NS);
  localparam int unsigned TW = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam int unsigned UW = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;

  logic [TW-1:0] tick_cnt;
  logic [UW-1:0] upd_cnt;

  assign tick_o = (tick_cnt == TW'(TC));
  assign upd_o  = tick_o && (upd_cnt == UW'(STEP_MS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      tick_cnt <= '0;
      upd_cnt  <= '0;
    end else begin
      if (tick_o) begin
        tick_cnt <= '0;
        if (upd_o) upd_cnt <= '0;
        else       upd_cnt <= upd_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Rate-limited servo target tracker: position_o moves at most STEP per update period, done_o is registered.
// Commands are accepted any cycle the block is enabled; a new command simply replaces the target.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_PER_NS = 40,
  parameter int unsigned N          = 8,
  parameter int unsigned STEP_MS    = 20,
  parameter int unsigned STEP       = 4,
  parameter int unsigned INIT_POS   = 2 ** (N - 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         cmd_valid_i,
  input  logic [N-1:0] cmd_target_i,
  output logic         cmd_ready_o,
  output logic [N-1:0] position_o,
  output logic         en_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [N:0]   STEP_W = (N + 1)'(STEP);
  localparam logic [N-1:0] STEP_N = N'(STEP);
  localparam logic [N-1:0] INIT_N = N'(INIT_POS);

  state_t        state_q;
  logic [N-1:0]  target_q;
  logic [N-1:0]  position_q;
  logic          done_q;

  logic          tick;
  logic          upd_pulse;
  logic          upd;
  logic          clr;
  logic          accept;
  logic [N-1:0]  eff_target;
  logic signed [N:0] diff;
  logic [N:0]    mag;
  logic          near;
  logic [N-1:0]  next_pos;

  assign cmd_ready_o = enable_i && (state_q != ST_OFF);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign en_o        = (state_q != ST_OFF);
  assign busy_o      = (state_q == ST_RAMP);
  assign done_o      = done_q;
  assign position_o  = position_q;

  // Counters idle at zero while off, and restart when a ramp begins from rest.
  assign clr = (state_q == ST_OFF)
            || ((state_q == ST_IDLE) && accept && (cmd_target_i != position_q));

  servo_ms_tick #(
    .CLK_PER_NS (CLK_PER_NS),
    .STEP_MS    (STEP_MS)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr),
    .tick_o (tick),
    .upd_o  (upd_pulse)
  );

  assign upd = tick && upd_pulse;

  // A retarget landing on an update edge steps toward the new target.
  assign eff_target = accept ? cmd_target_i : target_q;
  assign diff       = $signed({1'b0, eff_target}) - $signed({1'b0, position_q});
  assign mag        = diff[N] ? $unsigned(-diff) : $unsigned(diff);
  assign near       = (mag <= STEP_W);

  always_comb begin
    next_pos = eff_target;
    if (!near) begin
      if (diff[N]) next_pos = position_q - STEP_N;
      else         next_pos = position_q + STEP_N;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_OFF;
      position_q <= INIT_N;
      target_q   <= INIT_N;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!enable_i) begin
        state_q <= ST_OFF;
      end else begin
        case (state_q)
          ST_OFF: begin
            state_q <= ST_IDLE;
          end
          ST_IDLE: begin
            if (accept) begin
              target_q <= cmd_target_i;
              if (cmd_target_i == position_q) done_q  <= 1'b1;
              else                            state_q <= ST_RAMP;
            end
          end
          ST_RAMP: begin
            if (accept) target_q <= cmd_target_i;
            if (accept && (cmd_target_i == position_q)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else if (upd) begin
              position_q <= next_pos;
              if (near) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with an 11-cycle ms tick and a 22-cycle update period.
module tb_servo_ramp_ctrl;

  localparam int unsigned N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         cmd_valid_i;
  logic [N-1:0] cmd_target_i;
  logic         cmd_ready_o;
  logic [N-1:0] position_o;
  logic         en_o;
  logic         busy_o;
  logic         done_o;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always #5 clk_i = ~clk_i;

  servo_ramp_ctrl #(
    .CLK_PER_NS (100_000),
    .N          (N),
    .STEP_MS    (2),
    .STEP       (4),
    .INIT_POS   (128)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_target_i (cmd_target_i),
    .cmd_ready_o  (cmd_ready_o),
    .position_o   (position_o),
    .en_o         (en_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges, sampling 1ns after each and tallying done pulses.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o === 1'b1) done_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    enable_i    = 1'b1;
    cmd_valid_i = 1'b0;
    adv(1);
    rst_i = 1'b0;
    adv(1);
  endtask

  task automatic send(input logic [N-1:0] tgt);
    cmd_valid_i  = 1'b1;
    cmd_target_i = tgt;
    adv(1);
    cmd_valid_i  = 1'b0;
  endtask

  initial begin
    // 1: reset dominates enable and a pending command
    rst_i        = 1'b1;
    enable_i     = 1'b1;
    cmd_valid_i  = 1'b1;
    cmd_target_i = 8'd10;
    adv(2);
    chk("rst_en", en_o, 0);
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_pos", position_o, 128);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst_i       = 1'b0;
    cmd_valid_i = 1'b0;
    adv(1);
    chk("on_en", en_o, 1);
    chk("on_ready", cmd_ready_o, 1);
    chk("on_pos", position_o, 128);
    chk("on_busy", busy_o, 0);

    // 2: ramp 128 -> 140 in three updates
    send(8'd140);
    chk("r2_busy", busy_o, 1);
    adv(21);
    chk("r2_pos21", position_o, 128);
    adv(1);
    chk("r2_pos22", position_o, 132);
    chk("r2_done22", done_o, 0);
    adv(22);
    chk("r2_pos44", position_o, 136);
    adv(22);
    chk("r2_pos66", position_o, 140);
    chk("r2_done66", done_o, 1);
    chk("r2_busy66", busy_o, 0);
    adv(1);
    chk("r2_done67", done_o, 0);

    // 3: small move clamps straight onto target
    do_reset();
    send(8'd126);
    adv(22);
    chk("r3_pos", position_o, 126);
    chk("r3_done", done_o, 1);
    chk("r3_busy", busy_o, 0);

    // 4: retarget mid-ramp, single done at the end
    do_reset();
    send(8'd140);
    adv(22);
    chk("r4_pos132", position_o, 132);
    adv(5);
    send(8'd100);
    chk("r4_busy", busy_o, 1);
    adv(16);
    chk("r4_pos128", position_o, 128);
    adv(22);
    chk("r4_pos124", position_o, 124);
    done_cnt = 0;
    adv(132);
    chk("r4_pos100", position_o, 100);
    chk("r4_busy_end", busy_o, 0);
    chk("r4_done_cnt", done_cnt, 1);

    // 4b: retarget on the very update edge steps toward the new target
    do_reset();
    send(8'd140);
    adv(21);
    send(8'd100);
    chk("r4b_pos", position_o, 124);
    chk("r4b_busy", busy_o, 1);

    // 4c: retarget onto current position settles at once
    do_reset();
    send(8'd140);
    adv(22);
    send(8'd132);
    chk("r4c_busy", busy_o, 0);
    chk("r4c_done", done_o, 1);
    chk("r4c_pos", position_o, 132);

    // 5: disable mid-ramp freezes position, then reset mid-ramp
    do_reset();
    send(8'd140);
    adv(44);
    chk("r5_pos136", position_o, 136);
    adv(3);
    done_cnt = 0;
    enable_i = 1'b0;
    adv(1);
    chk("r5_en", en_o, 0);
    chk("r5_ready", cmd_ready_o, 0);
    chk("r5_busy", busy_o, 0);
    adv(60);
    chk("r5_pos_frozen", position_o, 136);
    chk("r5_no_done", done_cnt, 0);
    enable_i = 1'b1;
    adv(1);
    chk("r5_reen", en_o, 1);
    chk("r5_idle", busy_o, 0);
    chk("r5_pos_keep", position_o, 136);
    send(8'd140);
    adv(10);
    rst_i = 1'b1;
    adv(1);
    chk("r5_rst_pos", position_o, 128);
    chk("r5_rst_en", en_o, 0);
    chk("r5_rst_busy", busy_o, 0);
    rst_i = 1'b0;
    adv(1);

    // 6: command equal to position gives done without ramping
    send(8'd128);
    chk("r6_done", done_o, 1);
    chk("r6_busy", busy_o, 0);
    chk("r6_pos", position_o, 128);
    adv(1);
    chk("r6_done_clr", done_o, 0);
    chk("r6_busy2", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
